// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: periodically requests the shared bus, sends the read-key command
// (0x42), shifts in four scan bytes and publishes the eight board keys as a bitmap.
module tm1638_key_reader #(
  parameter int clk_frequency      = 27_000_000,
  parameter int sclk_frequency     = 500_000,
  parameter int wait_cycles        = 27,
  parameter int scan_period_cycles = 270_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       stb,
  output logic       sclk,
  output logic       dio_out,
  output logic       dio_oe,
  input  logic       dio_in,
  output logic [7:0] keys,
  output logic       keys_valid,
  output logic       keys_changed,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int H   = clk_frequency / (2 * sclk_frequency);
  localparam int CMX = (H > wait_cycles) ? H : wait_cycles;
  localparam int CW  = $clog2(CMX + 1);
  localparam int PW  = $clog2(scan_period_cycles + 1);

  localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
  localparam logic [CW-1:0] W_LAST   = CW'(wait_cycles - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(scan_period_cycles - 1);
  localparam logic [7:0]    CMD_READ = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_CMD, S_TURN, S_READ, S_END, S_DONE
  } state_t;

  // Handshake: bus_req stays high from REQ until DONE; the arbiter holds bus_gnt
  // high until bus_req drops, and bus_gnt is only looked at while in REQ.
  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [CW-1:0] phase_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_next;
  logic [31:0]   shift_reg;
  logic [7:0]    new_keys;
  logic          dio_meta;
  logic          dio_sync;

  assign state_dbg = state;
  assign bit_next  = bit_cnt + 5'd1;

  always_comb begin
    new_keys = '0;
    for (int i = 0; i < 4; i++) begin
      new_keys[i]     = shift_reg[8*i];
      new_keys[i + 4] = shift_reg[8*i + 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dio_meta <= 1'b1;
      dio_sync <= 1'b1;
    end else begin
      dio_meta <= dio_in;
      dio_sync <= dio_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      period_cnt   <= P_LAST;  // first scan starts right after reset
      phase_cnt    <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      stb          <= 1'b1;
      sclk         <= 1'b1;
      dio_out      <= 1'b1;
      dio_oe       <= 1'b0;
      bus_req      <= 1'b0;
      busy         <= 1'b0;
      keys         <= '0;
      keys_valid   <= 1'b0;
      keys_changed <= 1'b0;
    end else begin
      keys_valid   <= 1'b0;
      keys_changed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (period_cnt == P_LAST) begin
            period_cnt <= '0;
            bus_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= S_REQ;
          end else begin
            period_cnt <= period_cnt + PW'(1);
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            stb       <= 1'b0;
            dio_oe    <= 1'b1;
            dio_out   <= 1'b1;
            phase_cnt <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_cnt == H_LAST) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            dio_out   <= CMD_READ[0];
            state     <= S_CMD;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        S_CMD: begin
          if (phase_cnt != H_LAST) begin
            phase_cnt <= phase_cnt + CW'(1);
          end else begin
            phase_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt == 5'd7) begin
              dio_oe  <= 1'b0;
              dio_out <= 1'b1;
              state   <= S_TURN;
            end else begin
              bit_cnt <= bit_next;
              sclk    <= 1'b0;
              dio_out <= CMD_READ[bit_next[2:0]];
            end
          end
        end
        S_TURN: begin
          if (phase_cnt == W_LAST) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            state     <= S_READ;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        S_READ: begin
          if (phase_cnt != H_LAST) begin
            phase_cnt <= phase_cnt + CW'(1);
          end else begin
            phase_cnt <= '0;
            if (!sclk) begin
              // sample point sits H cycles after the falling edge, past the synchronizer delay
              sclk      <= 1'b1;
              shift_reg <= {dio_sync, shift_reg[31:1]};
            end else if (bit_cnt == 5'd31) begin
              state <= S_END;
            end else begin
              bit_cnt <= bit_next;
              sclk    <= 1'b0;
            end
          end
        end
        S_END: begin
          if (phase_cnt == H_LAST) begin
            phase_cnt <= '0;
            stb       <= 1'b1;
            state     <= S_DONE;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        S_DONE: begin
          bus_req      <= 1'b0;
          busy         <= 1'b0;
          keys         <= new_keys;
          keys_valid   <= 1'b1;
          keys_changed <= (new_keys != keys);
          period_cnt   <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a TM1638 model answers each scan, a monitor checks bus timing,
// and expected key bitmaps are queued per scan and compared when keys_valid pulses.
module tb_tm1638_key_reader;

  localparam int PERIOD   = 2000;
  localparam int HALF     = 27;
  localparam int STB_LOW  = 2241;
  localparam int BUDGET   = 8000;

  logic       clk;
  logic       rst_n;
  logic       bus_req;
  logic       bus_gnt;
  logic       stb;
  logic       sclk;
  logic       dio_out;
  logic       dio_oe;
  logic       dio_in;
  logic [7:0] keys;
  logic       keys_valid;
  logic       keys_changed;
  logic       busy;
  logic [2:0] state_dbg;

  tm1638_key_reader #(
    .clk_frequency(27_000_000),
    .sclk_frequency(500_000),
    .wait_cycles(27),
    .scan_period_cycles(PERIOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .stb(stb),
    .sclk(sclk),
    .dio_out(dio_out),
    .dio_oe(dio_oe),
    .dio_in(dio_in),
    .keys(keys),
    .keys_valid(keys_valid),
    .keys_changed(keys_changed),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_cnt = 0;
  int fall_cnt  = 0;

  logic [31:0] model_data = '0;
  logic [7:0]  last_keys  = '0;
  logic [7:0]  exp_q[$];
  logic        exp_chg_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] map_keys(input logic [31:0] d);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i]     = d[8*i];
      m[i + 4] = d[8*i + 4];
    end
    return m;
  endfunction

  // driver tasks
  task automatic push_scan(input logic [31:0] data);
    logic [7:0] k;
    model_data = data;
    k = map_keys(data);
    exp_q.push_back(k);
    exp_chg_q.push_back(k != last_keys);
    last_keys = k;
  endtask

  task automatic wait_valid(input int target);
    int n;
    n = 0;
    while (valid_cnt < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("keys_valid_count", valid_cnt, target);
  endtask

  // TM1638 model + bus monitor + scoreboard
  initial begin
    logic p_stb, p_sclk, p_oe, p_req;
    logic in_txn, have_valid;
    int stb_len, phase_len, rise_cnt, oe_fall_cyc, valid_cyc;
    logic [7:0] cmd_bits;
    logic [7:0] ek;
    logic ec;
    p_stb = 1'b1; p_sclk = 1'b1; p_oe = 1'b0; p_req = 1'b0;
    in_txn = 1'b0; have_valid = 1'b0;
    stb_len = 0; phase_len = 0; rise_cnt = 0; oe_fall_cyc = 0; valid_cyc = 0;
    cmd_bits = '0;
    dio_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        in_txn = 1'b0;
        have_valid = 1'b0;
        fall_cnt = 0;
        rise_cnt = 0;
        dio_in = 1'b1;
      end else begin
        if (bus_req && !p_req && have_valid) check("scan_period", cyc - valid_cyc, PERIOD);
        if (!stb && p_stb) begin
          in_txn = 1'b1; stb_len = 0; fall_cnt = 0; rise_cnt = 0; phase_len = 0;
        end
        if (in_txn) begin
          if (stb) begin
            check("stb_low_len", stb_len, STB_LOW);
            in_txn = 1'b0;
            dio_in = 1'b1;
          end else begin
            stb_len++;
            if (p_oe && !dio_oe) oe_fall_cyc = cyc;
            if (sclk != p_sclk) begin
              if (!sclk) begin
                if (fall_cnt != 0 && fall_cnt != 8) check("sclk_high_len", phase_len, HALF);
                if (fall_cnt == 8) begin
                  check("turnaround_gap", (cyc - oe_fall_cyc) >= 27, 1);
                  check("read_dio_oe", dio_oe, 0);
                end
                if (fall_cnt >= 8 && fall_cnt < 40) dio_in = model_data[fall_cnt - 8];
                fall_cnt++;
              end else begin
                check("sclk_low_len", phase_len, HALF);
                if (rise_cnt < 8) begin
                  cmd_bits[rise_cnt] = dio_out;
                  if (rise_cnt == 7) check("cmd_byte", cmd_bits, 8'h42);
                end
                rise_cnt++;
              end
              phase_len = 1;
            end else begin
              phase_len++;
            end
          end
        end
        if (keys_changed && !keys_valid) check("changed_without_valid", keys_changed, keys_valid);
        if (keys_valid) begin
          valid_cnt++;
          valid_cyc = cyc;
          have_valid = 1'b1;
          if (exp_q.size() == 0) begin
            check("expected_queue_size", exp_q.size(), 1);
          end else begin
            ek = exp_q.pop_front();
            ec = exp_chg_q.pop_front();
            check("keys", keys, ek);
            check("keys_changed", keys_changed, ec);
            check("busy_at_valid", busy, 0);
          end
        end
      end
      p_stb = stb; p_sclk = sclk; p_oe = dio_oe; p_req = bus_req;
    end
  end

  // directed sequence
  initial begin
    int n;
    int viol;
    rst_n   = 1'b0;
    bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stb", stb, 1);
    check("rst_sclk", sclk, 1);
    check("rst_dio_out", dio_out, 1);
    check("rst_dio_oe", dio_oe, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_keys", keys, 0);
    check("rst_keys_valid", keys_valid, 0);
    check("rst_keys_changed", keys_changed, 0);
    check("rst_busy", busy, 0);

    // scan 1: all keys released
    push_scan(32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("bus_req_after_reset", bus_req, 1);
    check("busy_after_reset", busy, 1);
    check("stb_still_high", stb, 1);
    wait_valid(1);

    // scan 2: key press, then an identical scan
    @(negedge clk);
    push_scan(32'h0000_1001);
    check("expected_press_map", last_keys, 8'h21);
    wait_valid(2);
    @(negedge clk);
    push_scan(32'h0000_1001);
    wait_valid(3);

    // scan 4: grant stall
    @(negedge clk);
    bus_gnt = 1'b0;
    push_scan(32'h0000_1001);
    n = 0;
    while (!bus_req && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("stall_bus_req", bus_req, 1);
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!(stb && sclk && bus_req && busy)) viol++;
    end
    check("stall_violations", viol, 0);
    bus_gnt = 1'b1;
    @(posedge clk);
    #2;
    check("stb_after_gnt", stb, 0);
    wait_valid(4);

    // scan 5: reset during READ bit 20, then a fresh scan
    @(negedge clk);
    model_data = 32'h0110_0011;
    n = 0;
    while (fall_cnt != 29 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("reached_read_bit20", fall_cnt, 29);
    rst_n = 1'b0;
    #1;
    check("midrst_stb", stb, 1);
    check("midrst_sclk", sclk, 1);
    check("midrst_dio_oe", dio_oe, 0);
    check("midrst_keys", keys, 0);
    check("midrst_bus_req", bus_req, 0);
    repeat (3) @(negedge clk);
    last_keys = 8'h00;
    push_scan(32'h0110_0011);
    check("expected_reset_map", last_keys, 8'h59);
    rst_n = 1'b1;
    wait_valid(5);

    // scans 6-8: all bits set, only ignored bits set, random
    @(negedge clk);
    push_scan(32'hFFFF_FFFF);
    wait_valid(6);
    @(negedge clk);
    push_scan(32'hEEEE_EEEE);
    wait_valid(7);
    @(negedge clk);
    push_scan($urandom());
    wait_valid(8);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
